linea_retardo_filtro: RTL and testbench

Parametrised multi-stage delay line (z^-1 chain) that stores the sample history for the recursive filter datapath. It generalises the single enabled register to Depth cascaded stages. It exposes every tap in parallel and one selectable tap. It also provides a synchronous clear and a fill counter / full flag, so the coefficient-multiply logic knows when the history is valid. It sits between the audio sample source and the filter MAC, clocked in the 44 kHz domain.

---
 rtl/linea_retardo_filtro.sv | 70 +++++++
 tb/tb_linea_retardo_filtro.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/linea_retardo_filtro.sv
// Multi-stage z^-1 delay line holding the sample history for the recursive filter.
// Every stage is exposed in parallel and one stage is also selectable via tapSel.
// A saturating fill counter tells the MAC how many stages hold real history.
module linea_retardo_filtro #(
    parameter int unsigned Width = 25,
    parameter int unsigned Depth = 4,
    localparam int unsigned SelW = $clog2(Depth)
) (
    input  logic                     clk44kHz,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [Width-1:0]         datoIn,
    input  logic [SelW-1:0]          tapSel,
    output logic [Width*Depth-1:0]   taps,
    output logic [Width-1:0]         tapOut,
    output logic [SelW:0]            fillCount,
    output logic                     lleno
);

    localparam logic [SelW:0] FillMax = (SelW + 1)'(Depth);

    logic [Width-1:0]       r_stage [Depth];
    logic [SelW:0]          r_fill;
    logic [Width*Depth-1:0] w_taps;
    logic [Width-1:0]       w_tap_out;

    // Stage chain and fill counter: clear beats enable, enable shifts, otherwise hold.
    always_ff @(posedge clk44kHz or negedge reset) begin
        if (!reset) begin
            r_stage <= '{default: '0};
            r_fill  <= '0;
        end else if (clear) begin
            r_stage <= '{default: '0};
            r_fill  <= '0;
        end else if (enable) begin
            r_stage[0] <= datoIn;
            for (int k = 1; k < Depth; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            if (r_fill < FillMax) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Flatten the stages onto the parallel tap bus, stage k in slice k.
    always_comb begin
        w_taps = '0;
        for (int k = 0; k < Depth; k++) begin
            w_taps[Width*k +: Width] = r_stage[k];
        end
    end

    // Selected tap; indices past the last stage (non power-of-two Depth) read as zero.
    always_comb begin
        w_tap_out = '0;
        for (int k = 0; k < Depth; k++) begin
            if (tapSel == SelW'(k)) begin
                w_tap_out = r_stage[k];
            end
        end
    end

    assign taps      = w_taps;
    assign tapOut    = w_tap_out;
    assign fillCount = r_fill;
    assign lleno     = (r_fill == FillMax);

endmodule

// File: tb/tb_linea_retardo_filtro.sv
// Scoreboard bench for linea_retardo_filtro: a queue-based history model predicts the
// line contents after every edge; a negedge monitor pops and compares.
module tb_linea_retardo_filtro;

    localparam int unsigned W  = 25;
    localparam int unsigned D  = 4;
    localparam int unsigned D5 = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  datoIn = '0;
    logic [1:0]    tapSel = '0;
    logic [W*D-1:0] taps;
    logic [W-1:0]  tapOut;
    logic [2:0]    fillCount;
    logic          lleno;

    logic           e5 = 1'b0;
    logic           c5 = 1'b0;
    logic [W-1:0]   din5 = '0;
    logic [2:0]     sel5 = '0;
    logic [W*D5-1:0] taps5;
    logic [W-1:0]   out5;
    logic [3:0]     fill5;
    logic           lleno5;

    always #5 clk = ~clk;

    linea_retardo_filtro #(.Width(W), .Depth(D)) dut (
        .clk44kHz (clk),
        .reset    (rst_n),
        .enable   (enable),
        .clear    (clear),
        .datoIn   (datoIn),
        .tapSel   (tapSel),
        .taps     (taps),
        .tapOut   (tapOut),
        .fillCount(fillCount),
        .lleno    (lleno)
    );

    linea_retardo_filtro #(.Width(W), .Depth(D5)) dut5 (
        .clk44kHz (clk),
        .reset    (rst_n),
        .enable   (e5),
        .clear    (c5),
        .datoIn   (din5),
        .tapSel   (sel5),
        .taps     (taps5),
        .tapOut   (out5),
        .fillCount(fill5),
        .lleno    (lleno5)
    );

    typedef struct {
        logic [W*D-1:0] taps;
        logic [2:0]     fill;
        logic           full;
        logic [W-1:0]   tap;
    } exp_t;

    exp_t        sb[$];
    logic [W-1:0] hist[$];  // newest sample first, at most D entries
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] stage_of(input int k);
        return (k < hist.size()) ? hist[k] : '0;
    endfunction

    // Drive one edge worth of inputs, advance the model, queue the expected state.
    task automatic step(input logic en, input logic clr, input logic [W-1:0] din,
                        input logic [1:0] sel);
        exp_t e;
        enable = en;
        clear  = clr;
        datoIn = din;
        @(posedge clk);
        #1;
        if (clr) begin
            hist.delete();
        end else if (en) begin
            hist.push_front(din);
            if (hist.size() > D) void'(hist.pop_back());
        end
        tapSel = sel;
        for (int k = 0; k < D; k++) e.taps[W*k +: W] = stage_of(k);
        e.fill = 3'(hist.size());
        e.full = (hist.size() == D);
        e.tap  = stage_of(int'(sel));
        sb.push_back(e);
    endtask

    // Monitor: state is stable at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("taps", 128'(taps), 128'(e.taps));
            chk("fillCount", 128'(fillCount), 128'(e.fill));
            chk("lleno", 128'(lleno), 128'(e.full));
            chk("tapOut", 128'(tapOut), 128'(e.tap));
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_taps"}, 128'(taps), 128'(0));
        chk({name, "_fill"}, 128'(fillCount), 128'(0));
        chk({name, "_lleno"}, 128'(lleno), 128'(0));
        chk({name, "_tapOut"}, 128'(tapOut), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low while clocking with enable high must keep everything at zero.
        enable = 1'b1;
        datoIn = 25'h1ABCDEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tapSel = 2'(i);
            #1;
            check_zero("in_reset");
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b1, 1'b0, 25'h1ABCDEF, 2'd0);
        step(1'b1, 1'b1, 25'h0, 2'd0);

        // Fill and shift past saturation.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 25'(i), 2'(i % 4));
        // Hold with garbage on the input.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 25'h0FFFFFF, 2'(i % 4));
        // Tap sweep on a stable line.
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 25'h0, 2'(s));

        // Clear wins over enable, then restart counting.
        step(1'b1, 1'b1, 25'd7, 2'd0);
        step(1'b1, 1'b0, 25'd9, 2'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                 25'($urandom), 2'($urandom));
        end

        // Async reset in the middle of a full line.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 25'($urandom), 2'(i));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_zero("async_hold");
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 25'($urandom), 2'($urandom));

        // Depth=5: out-of-range selects read zero.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e5   = 1'b1;
            din5 = 25'(11 + i);
        end
        @(negedge clk);
        e5 = 1'b0;
        chk("d5_lleno", 128'(lleno5), 128'(1));
        for (int s = 0; s < 8; s++) begin
            sel5 = 3'(s);
            #1;
            chk("d5_tapOut", 128'(out5), (s < 5) ? 128'(15 - s) : 128'(0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
